// File: rtl/watch_pkg.sv
// Shared definitions for the HH:MM[:SS] watch: FSM encodings, BCD field
// limits, the active-high 7-segment glyph table and BCD step helpers.
package watch_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SET_H = 2'd1,
        ST_SET_M = 2'd2,
        ST_SET_S = 2'd3
    } state_e;

    localparam logic [7:0] BCD_ZERO    = 8'h00;
    localparam logic [7:0] BCD_MS_MAX  = 8'h59;
    localparam logic [7:0] BCD_H24_MIN = 8'h00;
    localparam logic [7:0] BCD_H24_MAX = 8'h23;
    localparam logic [7:0] BCD_H12_MIN = 8'h01;
    localparam logic [7:0] BCD_H12_MAX = 8'h12;

    // Segment a is bit 0 ... g is bit 6; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Two-digit BCD increment that wraps from hi back to lo.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v == hi)
            r = lo;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

    // Two-digit BCD decrement that wraps from lo back to hi.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
        logic [7:0] r;
        if (v == lo)
            r = hi;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/seg7_dec.sv
// Combinational BCD to 7-segment decoder (active-high) with blanking.
module seg7_dec
    import watch_pkg::*;
(
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    // Table lookup; blank forces every segment off.
    always_comb begin
        seg_o = blank_i ? 7'd0 : SEG_TABLE[bcd_i];
    end

endmodule

// File: rtl/hms_watch_disp.sv
// Multiplexed HH:MM[:SS] watch with a RUN/SET FSM, BCD time counter and
// a registered digit-scan driver for a common LED display.
module hms_watch_disp
    import watch_pkg::*;
#(
    parameter int CLK_FRE  = 50_000_000,
    parameter int SCAN_DIV = 12_500,
    parameter int DIGITS   = 4,
    parameter int MODE_12H = 0,
    parameter int ACT_LOW  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_mode,
    input  logic              key_inc,
    input  logic              key_dec,
    output logic [DIGITS-1:0] dig,
    output logic [7:0]        smg,
    output logic              sec_led,
    output logic [1:0]        state
);

    localparam int                PRE_W    = (CLK_FRE > 1) ? $clog2(CLK_FRE) : 1;
    localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(CLK_FRE - 1);
    localparam logic [PRE_W-1:0]  PRE_HALF = PRE_W'(CLK_FRE / 2);
    localparam int                SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
    localparam logic [2:0]        IDX_MAX  = 3'(DIGITS - 1);
    localparam bit                AL       = (ACT_LOW != 0);
    localparam bit                H12      = (MODE_12H != 0);
    localparam logic [7:0]        HR_MIN   = H12 ? BCD_H12_MIN : BCD_H24_MIN;
    localparam logic [7:0]        HR_MAX   = H12 ? BCD_H12_MAX : BCD_H24_MAX;
    localparam logic [7:0]        HR_RST   = H12 ? BCD_H12_MAX : BCD_H24_MIN;

    state_e              state_q, state_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PRE_W-1:0]    blink_q, blink_d;
    logic [7:0]          hour_q, hour_d;
    logic [7:0]          min_q, min_d;
    logic [7:0]          sec_q, sec_d;
    logic [SCAN_W-1:0]   scan_cnt_q, scan_cnt_d;
    logic [2:0]          scan_idx_q, scan_idx_d;
    logic [DIGITS-1:0]   dig_q, dig_d;
    logic [7:0]          smg_q, smg_d;

    logic                is_run, sel_h, sel_m, sel_s;
    logic                edit_inc, edit_dec;
    logic                sec_tick, blink_on;
    logic [3:0]          cur_bcd;
    logic                cur_blank, cur_dp;
    logic [6:0]          cur_seg;
    logic [DIGITS-1:0]   onehot;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_RUN;
        else
            state_q <= state_d;
    end

    // FSM next state: key_mode steps through the set fields, back to RUN.
    always_comb begin
        state_d = state_q;
        if (key_mode) begin
            case (state_q)
                ST_RUN:   state_d = ST_SET_H;
                ST_SET_H: state_d = ST_SET_M;
                ST_SET_M: state_d = (DIGITS == 6) ? ST_SET_S : ST_RUN;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // FSM outputs: run flag and which field is being edited.
    always_comb begin
        is_run = (state_q == ST_RUN);
        sel_h  = (state_q == ST_SET_H);
        sel_m  = (state_q == ST_SET_M);
        sel_s  = (state_q == ST_SET_S);
    end

    // A mode press overrides edits, and a simultaneous inc+dec cancels out.
    assign edit_inc = key_inc & ~key_dec & ~key_mode;
    assign edit_dec = key_dec & ~key_inc & ~key_mode;

    // Second prescaler; parked at zero while editing so RUN restarts a full second.
    always_comb begin
        pre_d    = pre_q;
        sec_tick = 1'b0;
        if (!is_run) begin
            pre_d = '0;
        end else if (pre_q == PRE_MAX) begin
            pre_d    = '0;
            sec_tick = 1'b1;
        end else begin
            pre_d = pre_q + PRE_W'(1);
        end
    end

    // Free-running half-second phase used to blink the field under edit,
    // since the real prescaler is frozen outside RUN.
    always_comb begin
        blink_d = (blink_q == PRE_MAX) ? '0 : blink_q + PRE_W'(1);
    end

    assign blink_on = (blink_q < PRE_HALF);
    assign sec_led  = (pre_q < PRE_HALF);

    // Time update: carry chain on sec_tick, single-field wrap when editing.
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (sec_tick) begin
            sec_d = bcd_inc(sec_q, BCD_ZERO, BCD_MS_MAX);
            if (sec_q == BCD_MS_MAX) begin
                min_d = bcd_inc(min_q, BCD_ZERO, BCD_MS_MAX);
                if (min_q == BCD_MS_MAX)
                    hour_d = bcd_inc(hour_q, HR_MIN, HR_MAX);
            end
        end else if (edit_inc) begin
            if (sel_h) hour_d = bcd_inc(hour_q, HR_MIN, HR_MAX);
            if (sel_m) min_d  = bcd_inc(min_q, BCD_ZERO, BCD_MS_MAX);
            if (sel_s) sec_d  = bcd_inc(sec_q, BCD_ZERO, BCD_MS_MAX);
        end else if (edit_dec) begin
            if (sel_h) hour_d = bcd_dec(hour_q, HR_MIN, HR_MAX);
            if (sel_m) min_d  = bcd_dec(min_q, BCD_ZERO, BCD_MS_MAX);
            if (sel_s) sec_d  = bcd_dec(sec_q, BCD_ZERO, BCD_MS_MAX);
        end
    end

    // Scan slot timer: each digit is held for SCAN_DIV cycles.
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        scan_idx_d = scan_idx_q;
        if (scan_cnt_q == SCAN_MAX) begin
            scan_cnt_d = '0;
            scan_idx_d = (scan_idx_q == IDX_MAX) ? 3'd0 : scan_idx_q + 3'd1;
        end
    end

    // Pick the BCD digit, blanking and decimal point for the scanned position.
    always_comb begin
        cur_bcd   = 4'd0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        case (scan_idx_q)
            3'd0: begin
                cur_bcd   = hour_q[7:4];
                cur_blank = (sel_h && !blink_on) || (H12 && hour_q[7:4] == 4'd0);
            end
            3'd1: begin
                cur_bcd   = hour_q[3:0];
                cur_blank = sel_h && !blink_on;
                cur_dp    = is_run && sec_led;
            end
            3'd2: begin
                cur_bcd   = min_q[7:4];
                cur_blank = sel_m && !blink_on;
            end
            3'd3: begin
                cur_bcd   = min_q[3:0];
                cur_blank = sel_m && !blink_on;
                cur_dp    = is_run && sec_led && (DIGITS == 6);
            end
            3'd4: begin
                cur_bcd   = sec_q[7:4];
                cur_blank = sel_s && !blink_on;
            end
            3'd5: begin
                cur_bcd   = sec_q[3:0];
                cur_blank = sel_s && !blink_on;
            end
            default: cur_blank = 1'b1;
        endcase
    end

    seg7_dec u_seg7_dec (
        .bcd_i   (cur_bcd),
        .blank_i (cur_blank),
        .seg_o   (cur_seg)
    );

    // Output pattern with polarity applied before the register.
    always_comb begin
        onehot = DIGITS'(1) << scan_idx_q;
        dig_d  = onehot ^ {DIGITS{AL}};
        smg_d  = {cur_dp, cur_seg} ^ {8{AL}};
    end

    // Datapath and display registers; outputs sit dark during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q      <= '0;
            blink_q    <= '0;
            hour_q     <= HR_RST;
            min_q      <= BCD_ZERO;
            sec_q      <= BCD_ZERO;
            scan_cnt_q <= '0;
            scan_idx_q <= 3'd0;
            dig_q      <= {DIGITS{AL}};
            smg_q      <= {8{AL}};
        end else begin
            pre_q      <= pre_d;
            blink_q    <= blink_d;
            hour_q     <= hour_d;
            min_q      <= min_d;
            sec_q      <= sec_d;
            scan_cnt_q <= scan_cnt_d;
            scan_idx_q <= scan_idx_d;
            dig_q      <= dig_d;
            smg_q      <= smg_d;
        end
    end

    assign dig   = dig_q;
    assign smg   = smg_q;
    assign state = state_q;

endmodule

// File: doc/hms_watch_disp.md
HMS_WATCH_DISP -- requirements
Module: hms_watch_disp

Interface
REQ-001 SHALL have parameter CLK_FRE, default 50_000_000; input clock frequency in Hz.
REQ-002 SHALL have parameter SCAN_DIV, default 12_500; clk cycles per digit scan slot.
REQ-003 SHALL have parameter DIGITS, default 4; legal values 4 (HHMM) or 6 (HHMMSS).
REQ-004 SHALL have parameter MODE_12H, default 0; 0 = 24-hour, 1 = 12-hour.
REQ-005 SHALL have parameter ACT_LOW, default 1; 1 = dig and smg are active-low, 0 = active-high.
REQ-006 SHALL have port clk, input, 1, the single system clock.
REQ-007 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-008 SHALL have port key_mode, input, 1; single-cycle pulse, debounced externally.
REQ-009 SHALL have port key_inc, input, 1; single-cycle pulse.
REQ-010 SHALL have port key_dec, input, 1; single-cycle pulse.
REQ-011 SHALL have port dig, output, DIGITS; one-hot digit select, bit 0 = leftmost (hour tens).
REQ-012 SHALL have port smg, output, 8; segments a-g in bits 0-6, dp in bit 7.
REQ-013 SHALL have port sec_led, output, 1; high for the first half of each second.
REQ-014 SHALL have port state, output, 2; current FSM state encoding.

Function
REQ-015 SHALL produce a 1-cycle sec_tick every CLK_FRE cycles from a prescaler; sec_led SHALL be high while prescaler < CLK_FRE/2.
REQ-016 SHALL hold time as BCD hour, minute, and second fields; in RUN, sec_tick SHALL advance seconds with carry into minutes and hours.
REQ-017 SHALL wrap 23:59:59 -> 00:00:00 in 24h mode, and 12:59:59 -> 01:00:00 in 12h mode; hours SHALL stay in the range 1-12.
REQ-018 SHALL implement FSM states RUN=0, SET_H=1, SET_M=2, SET_S=3; key_mode SHALL step RUN->SET_H->SET_M->(SET_S if DIGITS==6)->RUN.
REQ-019 SHALL not advance time in any SET state; the prescaler SHALL be held at 0, so the first sec_tick after returning to RUN occurs exactly CLK_FRE cycles later.
REQ-020 In a SET state, key_inc/key_dec SHALL change only the selected field by +/-1 and wrap within that field's range (hours 0-23 or 1-12; min/sec 0-59), with no carry.
REQ-021 When key_inc and key_dec are both asserted in the same cycle, both SHALL be ignored; when key_mode coincides with inc/dec, the mode change SHALL win and inc/dec SHALL be ignored.
REQ-022 SHALL ignore key_inc/key_dec in RUN.
REQ-023 SHALL select digit index k (0..DIGITS-1) for SCAN_DIV cycles each, cycling upward and wrapping to 0.
REQ-024 SHALL register dig and smg, updating both on the same edge one cycle after the scan index changes.
REQ-025 In a SET state, the selected field's two digits SHALL be blanked (all segments off) while sec_led would be low; other digits SHALL stay lit.
REQ-026 In 12h mode, an hour-tens value of 0 SHALL be blanked.
REQ-027 dp SHALL be lit on the hour-ones digit (and the minute-ones digit if DIGITS==6) only in RUN while sec_led is high.
REQ-028 When ACT_LOW==1, SHALL invert dig and smg at the output register.

Reset
REQ-029 On rst SHALL set: state=RUN, prescaler=0, scan index=0, and time to 00:00:00 (24h) or 12:00:00 (12h).
REQ-030 During reset SHALL drive all digits off, all segments off (at inactive polarity), and sec_led=1.
REQ-031 If rst asserts mid-set, pending edits SHALL be discarded and time SHALL return to its reset value.

Structure
REQ-032 Package watch_pkg SHALL hold the state encodings, BCD limits, and the 16-entry 7-segment pattern table (active-high).
REQ-033 Sub-module seg7_dec SHALL be combinational: 4-bit BCD plus blank in, 7 segments out.
REQ-034 The time counter, FSM, and scan logic SHALL reside in hms_watch_disp.

Verification (CLK_FRE=8, SCAN_DIV=2)
REQ-035 Reset, then 8*60 cycles, DIGITS=4, 24h -> time 00:01; the dig sequence is 0001,0010,0100,1000 repeating every 8 cycles (ACT_LOW=0).
REQ-036 Preload 23:59:59, one sec_tick -> 00:00:00; with MODE_12H=1, preload 12:59:59 -> 01:00:00.
REQ-037 key_mode, then 3 key_dec in SET_H from 00 -> hour 21, minutes unchanged; hour digits blank when sec_led=0.
REQ-038 key_inc and key_dec in the same cycle in SET_M -> no change; key_mode with key_inc -> state advances, field unchanged.
REQ-039 Exit a SET state to RUN -> first sec_tick exactly 8 cycles later; rst mid-SET_M -> state 0, time 00:00:00, dig all inactive.
